btn_debounce: RTL and testbench
===============================

Name: btn_debounce

Overview:
- Input-side counterpart to the board's LED output path: conditions a raw iCEBreaker push-button pad into a clean, synchronous level plus single-cycle press and release events.
- Sits directly behind the SB_IO input buffer of a BTN pin, in the CLK domain.
- Feeds user logic: LED drivers, mode selectors and counters.

Parameters:
- DEBOUNCE_CYCLES, 120000, number of consecutive CLK cycles the synchronised input must differ from the stable state before a change is accepted (10 ms at 12 MHz); legal minimum 2.
- ACTIVE_LOW, 0, 1 when the pad reads 0 while pressed (BTN_N); 0 for BTN1..BTN3.
- LONG_CYCLES, 12000000, hold time for a long-press event (1 s at 12 MHz); used only with LONG_PRESS_EN.

Ports:
- CLK  input  1  system clock; all logic is on its rising edge.
- RST  input  1  synchronous, active-high reset.
- BTN_IN  input  1  raw pad value from SB_IO D_IN_0; asynchronous to CLK.
- BTN_LEVEL  output  1  debounced state, 1 = pressed, regardless of ACTIVE_LOW.
- BTN_PRESS  output  1  one-cycle pulse when BTN_LEVEL goes 0->1.
- BTN_RELEASE  output  1  one-cycle pulse when BTN_LEVEL goes 1->0.
- BTN_LONG  output  1  one-cycle long-press pulse; present only with LONG_PRESS_EN.

Behaviour:
- Polarity: raw = BTN_IN XOR ACTIVE_LOW, then a 2-FF synchroniser produces sync_btn. Synchroniser flops reset to 0 (released).
- Reset: state RELEASED, counter 0, BTN_LEVEL=0, BTN_PRESS=0, BTN_RELEASE=0, BTN_LONG=0.
  - Reset asserted mid-debounce or mid-hold discards all progress.
  - No pulses are emitted on reset entry or exit.
- Counter width: clog2(DEBOUNCE_CYCLES). It never exceeds DEBOUNCE_CYCLES-1.
- FSM states:
  - RELEASED: if sync_btn=1, go to PRESS_WAIT with cnt=1; otherwise cnt=0.
  - PRESS_WAIT: if sync_btn=0, return to RELEASED with cnt=0 (glitch rejected, no pulse). Else if cnt==DEBOUNCE_CYCLES-1, go to HELD, set BTN_LEVEL=1 and pulse BTN_PRESS. Else cnt++.
  - HELD: if sync_btn=0, go to RELEASE_WAIT with cnt=1; otherwise cnt=0.
  - RELEASE_WAIT: if sync_btn=1, return to HELD with cnt=0. Else if cnt==DEBOUNCE_CYCLES-1, go to RELEASED, set BTN_LEVEL=0 and pulse BTN_RELEASE. Else cnt++.
- Latency: number the first CLK edge that samples the new raw level as edge 1. BTN_LEVEL and its pulse are registered outputs visible after edge DEBOUNCE_CYCLES+2.
- Pulses last exactly one cycle. BTN_PRESS and BTN_RELEASE are never high in the same cycle.
- Two accepted transitions are at least DEBOUNCE_CYCLES cycles apart.
- Bounce at any point: any reversal shorter than DEBOUNCE_CYCLES cycles produces no output change.

Optional Feature:
- Macro: BTN_DEBOUNCE_LONG_PRESS_EN.
- Defined:
  - A long counter of width clog2(LONG_CYCLES) runs while in HELD or RELEASE_WAIT and clears on entry to HELD from PRESS_WAIT.
  - When it reaches LONG_CYCLES-1, BTN_LONG pulses once and the counter saturates; at most one BTN_LONG per press.
  - The long counter clears on RELEASED and on reset.
- Undefined: the BTN_LONG port and the long counter are absent; all other behaviour is identical.

Decomposition:
- Shared include btn_pkg.vh holds:
  - state encoding localparams ST_RELEASED, ST_PRESS_WAIT, ST_HELD, ST_RELEASE_WAIT (2 bits);
  - default timing constants for the 12 MHz board clock.
- One sub-module, btn_sync2: 2-FF synchroniser with synchronous reset to 0, reusable for the other BTN pins.

Test Plan (DEBOUNCE_CYCLES=4, LONG_CYCLES=10 unless noted):
- Clean press: BTN_IN 0->1 held (ACTIVE_LOW=0) -> BTN_LEVEL=1 and a single BTN_PRESS pulse after edge 6; no BTN_RELEASE.
- Bounce rejection: BTN_IN pulses high for 3 cycles, then low for 3 cycles, repeated 5 times -> BTN_LEVEL stays 0, no pulses.
- Release: from HELD, BTN_IN 1->0 held -> BTN_LEVEL=0 and one BTN_RELEASE pulse after edge 6; a 2-cycle low glitch while held produces nothing.
- Active-low: ACTIVE_LOW=1, BTN_IN idles 1, then 1->0 -> BTN_PRESS pulses; no pulse at reset exit.
- Reset mid-operation: assert RST during PRESS_WAIT (cnt=2) and deassert with BTN_IN still high -> outputs 0 during reset; press accepted 6 edges after deassertion, not earlier.
- Long press (macro defined): hold 30 cycles -> exactly one BTN_LONG pulse, 10 cycles after BTN_PRESS; release then re-press 3 cycles -> no BTN_LONG.

Source files
------------

// File: rtl/btn_debounce_pkg.sv
// Shared constants for the push-button conditioning path.
// State encoding and default timing for the 12 MHz board clock.
package btn_debounce_pkg;

  localparam logic [1:0] ST_RELEASED     = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_HELD         = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 120000;
  localparam int unsigned DEF_LONG_CYCLES     = 12000000;

  function automatic int unsigned cnt_width(input int unsigned n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce_sync2.sv
// Two-flop synchroniser, synchronous reset to 0 (released).
// Reused by every BTN pin in the CLK domain.
module btn_sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/btn_debounce.sv
// Push-button debouncer: clean level plus press/release pulses.
// Define BTN_DEBOUNCE_LONG_PRESS_EN to add the BTN_LONG event.
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit          ACTIVE_LOW      = 1'b0
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
  , parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES
`endif
) (
  input  logic CLK,
  input  logic RST,
  input  logic BTN_IN,
  output logic BTN_LEVEL,
  output logic BTN_PRESS,
  output logic BTN_RELEASE
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
  , output logic BTN_LONG
`endif
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic raw;
  logic sync_btn;

  assign raw = BTN_IN ^ ACTIVE_LOW;

  btn_sync2 u_sync (
    .clk_i (CLK),
    .rst_i (RST),
    .d_i   (raw),
    .q_o   (sync_btn)
  );

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    unique case (state_q)
      ST_RELEASED: begin
        if (sync_btn) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_PRESS_WAIT: begin
        if (!sync_btn) begin
          state_d = ST_RELEASED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HELD;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HELD: begin
        if (!sync_btn) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_RELEASE_WAIT: begin
        if (sync_btn) begin
          state_d = ST_HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_RELEASED;
          level_d = 1'b0;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_RELEASED;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_RELEASED;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign BTN_LEVEL   = level_q;
  assign BTN_PRESS   = press_q;
  assign BTN_RELEASE = rel_q;

`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
  localparam int unsigned LONG_W = cnt_width(LONG_CYCLES);
  localparam logic [LONG_W-1:0] LONG_LAST =
    LONG_W'(LONG_CYCLES - 1);

  logic [LONG_W-1:0] lcnt_q, lcnt_d;
  logic              fired_q, fired_d;
  logic              long_q, long_d;
  logic              holding;

  // Count only while staying in HELD/RELEASE_WAIT; a fresh press restarts.
  assign holding = (state_q == ST_HELD || state_q == ST_RELEASE_WAIT)
                && (state_d == ST_HELD || state_d == ST_RELEASE_WAIT);

  always_comb begin
    lcnt_d  = '0;
    fired_d = 1'b0;
    long_d  = 1'b0;
    if (holding) begin
      lcnt_d  = lcnt_q;
      fired_d = fired_q;
      if (lcnt_q == LONG_LAST) begin
        if (!fired_q) begin
          long_d  = 1'b1;
          fired_d = 1'b1;
        end
      end else begin
        lcnt_d = lcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      lcnt_q  <= '0;
      fired_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      lcnt_q  <= lcnt_d;
      fired_q <= fired_d;
      long_q  <= long_d;
    end
  end

  assign BTN_LONG = long_q;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: run-length model plus directed literals.
// Long-press checks compile in with BTN_DEBOUNCE_LONG_PRESS_EN.
module tb_btn_debounce;

  localparam int D = 4;
  localparam int L = 10;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic btn0 = 1'b0;
  logic btn1 = 1'b1;

  logic [1:0] lvl, prs, rel, lng;

  int checks = 0;
  int errors = 0;

  btn_debounce #(
    .DEBOUNCE_CYCLES(D),
    .ACTIVE_LOW(1'b0)
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
    , .LONG_CYCLES(L)
`endif
  ) u0 (
    .CLK(clk),
    .RST(rst),
    .BTN_IN(btn0),
    .BTN_LEVEL(lvl[0]),
    .BTN_PRESS(prs[0]),
    .BTN_RELEASE(rel[0])
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
    , .BTN_LONG(lng[0])
`endif
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(D),
    .ACTIVE_LOW(1'b1)
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
    , .LONG_CYCLES(L)
`endif
  ) u1 (
    .CLK(clk),
    .RST(rst),
    .BTN_IN(btn1),
    .BTN_LEVEL(lvl[1]),
    .BTN_PRESS(prs[1]),
    .BTN_RELEASE(rel[1])
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
    , .BTN_LONG(lng[1])
`endif
  );

`ifndef BTN_DEBOUNCE_LONG_PRESS_EN
  assign lng = 2'b00;
`endif

  always #5 clk = ~clk;

  task automatic check(input string nm, input int i,
                       input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] t=%0t got=%b want=%b",
               nm, i, $time, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act,
                           input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0d want=%0d",
               nm, $time, act, exp);
    end
  endtask

  // Model: pad value reaches the decision two edges late; a level
  // flips once the delayed input has disagreed with it D edges running.
  logic [1:0] h1, h2, m_lvl, m_prs, m_rel, m_lng;
  int run [2];
  int hc [2];
  int n_press [2];
  int n_rel [2];
  int n_long [2];
  logic raw_b, s;

  initial begin
    for (int i = 0; i < 2; i++) begin
      n_press[i] = 0;
      n_rel[i]   = 0;
      n_long[i]  = 0;
      run[i]     = 0;
      hc[i]      = L;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      raw_b = (i == 0) ? btn0 : ~btn1;
      if (rst) begin
        h1[i] = 1'b0; h2[i] = 1'b0;
        m_lvl[i] = 1'b0; m_prs[i] = 1'b0;
        m_rel[i] = 1'b0; m_lng[i] = 1'b0;
        run[i] = 0; hc[i] = L;
      end else begin
        s = h2[i];
        h2[i] = h1[i];
        h1[i] = raw_b;
        m_prs[i] = 1'b0; m_rel[i] = 1'b0; m_lng[i] = 1'b0;
        if (s != m_lvl[i]) begin
          run[i]++;
          if (run[i] == D) begin
            m_lvl[i] = s;
            m_prs[i] = s;
            m_rel[i] = ~s;
            run[i] = 0;
            hc[i] = 0;
          end
        end else begin
          run[i] = 0;
        end
        if (m_lvl[i] && !m_prs[i] && hc[i] < L) begin
          hc[i]++;
          if (hc[i] == L) m_lng[i] = 1'b1;
        end
      end
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      check("level", i, lvl[i], m_lvl[i]);
      check("press", i, prs[i], m_prs[i]);
      check("release", i, rel[i], m_rel[i]);
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
      check("long", i, lng[i], m_lng[i]);
`endif
      if (prs[i]) n_press[i]++;
      if (rel[i]) n_rel[i]++;
      if (lng[i]) n_long[i]++;
    end
  end

  task automatic at_edge(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  int base;
  int base_long;

  initial begin
    rst = 1'b1; btn0 = 1'b0; btn1 = 1'b1;
    at_edge(2);
    check("rst_level", 0, lvl[0], 1'b0);
    check("rst_press", 1, prs[1], 1'b0);

    @(negedge clk) rst = 1'b0;
    at_edge(6);
    check("exit_level", 1, lvl[1], 1'b0);
    check_int("exit_press_cnt", n_press[1], 0);

    // Clean press on both pins.
    @(negedge clk) begin btn0 = 1'b1; btn1 = 1'b0; end
    at_edge(5);
    check("press_early", 0, lvl[0], 1'b0);
    check("press_early", 1, lvl[1], 1'b0);
    at_edge(1);
    check("press_lvl", 0, lvl[0], 1'b1);
    check("press_pulse", 0, prs[0], 1'b1);
    check("press_pulse", 1, prs[1], 1'b1);
    at_edge(1);
    check("press_one", 0, prs[0], 1'b0);
    check_int("press_cnt", n_press[0], 1);
    check_int("no_release", n_rel[0], 0);

    // Two-cycle low glitch while held.
    repeat (4) @(negedge clk);
    btn0 = 1'b0; btn1 = 1'b1;
    repeat (2) @(negedge clk);
    btn0 = 1'b1; btn1 = 1'b0;
    at_edge(8);
    check("glitch_lvl", 0, lvl[0], 1'b1);
    check_int("glitch_rel", n_rel[0], 0);

    // Clean release.
    @(negedge clk) begin btn0 = 1'b0; btn1 = 1'b1; end
    at_edge(5);
    check("rel_early", 0, lvl[0], 1'b1);
    at_edge(1);
    check("rel_pulse", 0, rel[0], 1'b1);
    check("rel_pulse", 1, rel[1], 1'b1);
    check("rel_lvl", 0, lvl[0], 1'b0);
    at_edge(1);
    check_int("rel_cnt", n_rel[0], 1);

    // Bounce: 3 high / 3 low, five times.
    base = n_press[0];
    for (int k = 0; k < 5; k++) begin
      @(negedge clk) begin btn0 = 1'b1; btn1 = 1'b0; end
      repeat (3) @(negedge clk);
      btn0 = 1'b0; btn1 = 1'b1;
      repeat (2) @(negedge clk);
    end
    @(negedge clk);
    at_edge(6);
    check("bounce_lvl", 0, lvl[0], 1'b0);
    check_int("bounce_press", n_press[0], base);

    // Reset with PRESS_WAIT part-way through.
    @(negedge clk) begin btn0 = 1'b1; btn1 = 1'b0; end
    at_edge(4);
    @(negedge clk) rst = 1'b1;
    at_edge(2);
    check("mid_rst_lvl", 0, lvl[0], 1'b0);
    check("mid_rst_prs", 0, prs[0], 1'b0);
    @(negedge clk) rst = 1'b0;
    at_edge(5);
    check("post_rst_early", 0, lvl[0], 1'b0);
    at_edge(1);
    check("post_rst_lvl", 0, lvl[0], 1'b1);
    check("post_rst_prs", 0, prs[0], 1'b1);
    base_long = n_long[0];

`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
    at_edge(9);
    check("long_early", 0, lng[0], 1'b0);
    at_edge(1);
    check("long_pulse", 0, lng[0], 1'b1);
    at_edge(20);
    check_int("long_once", n_long[0], base_long + 1);
`else
    at_edge(30);
`endif

    // Release, then a short 3-cycle re-press.
    @(negedge clk) begin btn0 = 1'b0; btn1 = 1'b1; end
    repeat (10) @(negedge clk);
    btn0 = 1'b1; btn1 = 1'b0;
    repeat (3) @(negedge clk);
    btn0 = 1'b0; btn1 = 1'b1;
    at_edge(15);
    check("short_lvl", 0, lvl[0], 1'b0);
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
    check_int("short_long", n_long[0], base_long + 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1);
  end

endmodule
